zero_cross_search: RTL and testbench
====================================

# zero_cross_search

Parametrised successor to the phase-matching search stage. Takes one window of signed error samples and their positions per beat. Locates a sign crossing between adjacent samples, selected by a runtime edge mode and priority, and emits the bracketing position and errors for the downstream linear-interpolation stage. The block adds ready/valid backpressure on both sides, a found flag, a crossing index and a crossing count. Phase-1 position, not-found and tlast sidebands ride through in lock-step with the data.

## Interface
- DATA_WIDTH, 16: width of error, position and phase-1 position words (signed).
- WIN_SIZE, 32: samples per window; legal range 2..256.
- IDX_W, $clog2(WIN_SIZE): width of the index and count outputs.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_vld  in  1  input beat valid.
- s_rdy  out  1  input beat accepted when s_vld & s_rdy.
- error_i  in  WIN_SIZE x DATA_WIDTH  signed error samples; index 0 is the first sample.
- pos_i  in  WIN_SIZE x DATA_WIDTH  signed sample positions.
- abs_phase1_pos_i  in  DATA_WIDTH  sideband, passed through.
- not_found_i  in  1  upstream not-found flag.
- tlast_i  in  1  last beat of frame.
- mode_i  in  2  edge select, sampled per beat: 00 falling, 01 rising, 10 either, 11 treated as 00.
- first_i  in  1  priority, sampled per beat: 1 selects the lowest-index crossing, 0 selects the highest.
- m_vld  out  1  output beat valid.
- m_rdy  in  1  downstream ready.
- x0  out  DATA_WIDTH  pos_i[k] of the selected pair (k, k+1).
- y_sub_y0, y_sub_y1  out  DATA_WIDTH each  error_i[k] and error_i[k+1].
- idx_o  out  IDX_W  k.
- cnt_o  out  IDX_W  number of pairs matching mode_i (0..WIN_SIZE-1).
- found_o  out  1  cnt_o != 0.
- abs_phase1_pos_o, tlast_o  out  passed-through sidebands.
- not_found_o  out  1  not_found_i | ~found_o.

## Operation
- Falling edge at pair i: error[i] >= 0 and error[i+1] < 0. This is a sign-bit test; zero counts as non-negative.
- Rising edge at pair i: error[i] < 0 and error[i+1] >= 0.
- Pairs considered: i = 0..WIN_SIZE-2.
- Selection: a priority encode over the match vector, in the direction set by first_i.
- No match:
  - k = 0, so x0 = pos_i[0], y_sub_y0 = error_i[0], y_sub_y1 = error_i[1].
  - idx_o = 0, cnt_o = 0, found_o = 0.
  - not_found_o = 1.
- Every sideband (mode, first, tlast, not_found, abs_phase1_pos) is captured with its data beat and never mixes across beats.
- Pipeline stages:
  - S0 registers the inputs.
  - S1 computes the match vector, priority encode, popcount and mux, then registers the outputs.
  - Each stage has its own valid bit.
- Advance rules:
  - adv1 = ~v1 | m_rdy.
  - adv0 = ~v0 | adv1.
  - s_rdy = adv0. This is a combinational path from m_rdy; no skid buffer.
- A stage loads only when its advance term is high. Its data registers hold otherwise.

## Timing
- Latency is 2 cycles from an accepted input beat to m_vld with that beat's result, when unstalled.
- Throughput is 1 beat/cycle while m_rdy = 1.
- Stall: while m_vld & ~m_rdy, every output holds stable. s_rdy drops once v0 is also occupied. No beat is dropped or duplicated.
- Simultaneous events: input accept and output retire in the same cycle is legal at full rate.
- Reset (asynchronous) clears v0, v1, m_vld, tlast_o, found_o, not_found_o, idx_o, cnt_o and all data outputs to 0. Beats in flight are discarded.
- s_rdy = 1 during and right after reset, because both stages are empty.

## Structure
- Shared package pmp_pkg holds:
  - typedef enum logic[1:0] zc_mode_e {ZC_FALL, ZC_RISE, ZC_BOTH, ZC_RSVD}.
  - The IDX_W helper function.
- Sub-module zc_prio_enc: match vector plus first_i in; index, any-hit and popcount out; purely combinational, instantiated in S1.

## Test plan
- WIN_SIZE=8, errors {5,3,1,-2,-4,-6,-8,-9}, mode 00, first 1:
  - idx_o=2, x0=pos[2], y_sub_y0=1, y_sub_y1=-2.
  - cnt_o=1, found_o=1.
  - m_vld exactly 2 cycles after accept.
- Errors {2,-1,3,-1,0,-5,4,4}:
  - mode 00, first 0: idx 4, cnt 3.
  - mode 00, first 1: idx 0.
  - mode 10, first 0: idx 5, cnt 6.
- All errors positive:
  - found_o=0, not_found_o=1.
  - x0=pos[0], y_sub_y0=err[0], y_sub_y1=err[1].
- Back-to-back 20 beats with random m_rdy (50%): outputs arrive in order, no loss or duplication, outputs stable while m_rdy=0, tlast marks beat 20 only.
- Assert rst for 1 cycle while both stages are full:
  - m_vld and all outputs drop to 0 immediately.
  - s_rdy=1 on release.
  - The next beat's result appears 2 cycles after accept.
- Zero boundary: error[i]=0, error[i+1]=-1 counts as falling; error[i]=-1, error[i+1]=0 counts as rising, in the matching modes only.

Source files
------------

// File: rtl/pmp_pkg.sv
// Shared types and helpers for the phase-matching pipeline blocks.
// Holds the edge-mode encoding and the index-width rule.
package pmp_pkg;

  typedef enum logic [1:0] {
    ZC_FALL = 2'b00,
    ZC_RISE = 2'b01,
    ZC_BOTH = 2'b10,
    ZC_RSVD = 2'b11
  } zc_mode_e;

  function automatic int zc_idx_w(input int win);
    return $clog2(win);
  endfunction

endpackage

// File: rtl/zero_cross_search_if.sv
// Beat-level bus for zero_cross_search: input window with sidebands, plus the
// interpolation-bracket result with ready/valid on both sides.
interface zero_cross_search_if
  import pmp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_SIZE   = 32,
  parameter int IDX_W      = zc_idx_w(WIN_SIZE)
);
  logic                                s_vld;
  logic                                s_rdy;
  logic [WIN_SIZE-1:0][DATA_WIDTH-1:0] error_i;
  logic [WIN_SIZE-1:0][DATA_WIDTH-1:0] pos_i;
  logic [DATA_WIDTH-1:0]               abs_phase1_pos_i;
  logic                                not_found_i;
  logic                                tlast_i;
  logic [1:0]                          mode_i;
  logic                                first_i;

  logic                                m_vld;
  logic                                m_rdy;
  logic [DATA_WIDTH-1:0]               x0;
  logic [DATA_WIDTH-1:0]               y_sub_y0;
  logic [DATA_WIDTH-1:0]               y_sub_y1;
  logic [IDX_W-1:0]                    idx_o;
  logic [IDX_W-1:0]                    cnt_o;
  logic                                found_o;
  logic [DATA_WIDTH-1:0]               abs_phase1_pos_o;
  logic                                tlast_o;
  logic                                not_found_o;

  modport slave (
    input  s_vld, error_i, pos_i, abs_phase1_pos_i, not_found_i, tlast_i,
           mode_i, first_i, m_rdy,
    output s_rdy, m_vld, x0, y_sub_y0, y_sub_y1, idx_o, cnt_o, found_o,
           abs_phase1_pos_o, tlast_o, not_found_o
  );

  modport master (
    output s_vld, error_i, pos_i, abs_phase1_pos_i, not_found_i, tlast_i,
           mode_i, first_i, m_rdy,
    input  s_rdy, m_vld, x0, y_sub_y0, y_sub_y1, idx_o, cnt_o, found_o,
           abs_phase1_pos_o, tlast_o, not_found_o
  );

endinterface

// File: rtl/zc_prio_enc.sv
// Direction-selectable priority encoder with hit flag and popcount over the
// crossing match vector. Purely combinational.
module zc_prio_enc #(
  parameter int NP    = 31,
  parameter int IDX_W = 5
) (
  input  logic [NP-1:0]    match_i,
  input  logic             first_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             hit_o,
  output logic [IDX_W-1:0] cnt_o
);

  always_comb begin
    idx_o = '0;
    cnt_o = '0;
    for (int i = 0; i < NP; i++) begin
      cnt_o = cnt_o + IDX_W'(match_i[i]);
    end
    // Last write wins, so the scan direction decides which end has priority.
    if (first_i) begin
      for (int i = NP - 1; i >= 0; i--) begin
        if (match_i[i]) idx_o = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (match_i[i]) idx_o = IDX_W'(i);
      end
    end
  end

  assign hit_o = |match_i;

endmodule

// File: rtl/zero_cross_search.sv
// Two-stage sign-crossing search: S0 captures a window, S1 selects the bracketing
// pair and registers it for the interpolator. Sidebands travel with their beat.
module zero_cross_search
  import pmp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_SIZE   = 32
) (
  input logic               clk,
  input logic               rst,
  zero_cross_search_if.slave bus
);

  localparam int IDX_W = zc_idx_w(WIN_SIZE);
  localparam int NP    = WIN_SIZE - 1;
  localparam int SB    = DATA_WIDTH - 1;

  logic adv0, adv1;

  logic                                v0_q;
  logic [WIN_SIZE-1:0][DATA_WIDTH-1:0] err0_q, pos0_q;
  logic [DATA_WIDTH-1:0]               ph0_q;
  logic                                nf0_q, tl0_q, first0_q;
  logic [1:0]                          mode0_q;

  logic                  v1_q;
  logic [DATA_WIDTH-1:0] x0_q, y0_q, y1_q, ph1_q;
  logic [IDX_W-1:0]      idx_q, cnt_q;
  logic                  found_q, nf1_q, tl1_q;

  logic [NP-1:0]         match;
  logic [IDX_W-1:0]      k, k1, cnt;
  logic                  hit;
  logic [DATA_WIDTH-1:0] x0_d, y0_d, y1_d;

  // Upstream ready is combinational from m_rdy; there is no skid buffer.
  assign adv1      = ~v1_q | bus.m_rdy;
  assign adv0      = ~v0_q | adv1;
  assign bus.s_rdy = adv0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q     <= 1'b0;
      err0_q   <= '0;
      pos0_q   <= '0;
      ph0_q    <= '0;
      nf0_q    <= 1'b0;
      tl0_q    <= 1'b0;
      first0_q <= 1'b0;
      mode0_q  <= '0;
    end else if (adv0) begin
      v0_q     <= bus.s_vld;
      err0_q   <= bus.error_i;
      pos0_q   <= bus.pos_i;
      ph0_q    <= bus.abs_phase1_pos_i;
      nf0_q    <= bus.not_found_i;
      tl0_q    <= bus.tlast_i;
      first0_q <= bus.first_i;
      mode0_q  <= bus.mode_i;
    end
  end

  // Sign-bit tests only: zero is treated as non-negative.
  always_comb begin
    match = '0;
    for (int i = 0; i < NP; i++) begin
      case (zc_mode_e'(mode0_q))
        ZC_RISE: match[i] = err0_q[i][SB] & ~err0_q[i+1][SB];
        ZC_BOTH: match[i] = err0_q[i][SB] ^ err0_q[i+1][SB];
        default: match[i] = ~err0_q[i][SB] & err0_q[i+1][SB];
      endcase
    end
  end

  zc_prio_enc #(
    .NP    (NP),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .match_i (match),
    .first_i (first0_q),
    .idx_o   (k),
    .hit_o   (hit),
    .cnt_o   (cnt)
  );

  // k never exceeds WIN_SIZE-2, so k+1 stays in range and in width.
  assign k1   = k + IDX_W'(1);
  assign x0_d = pos0_q[k];
  assign y0_d = err0_q[k];
  assign y1_d = err0_q[k1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      nf1_q   <= 1'b0;
      ph1_q   <= '0;
      tl1_q   <= 1'b0;
    end else if (adv1) begin
      v1_q    <= v0_q;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      idx_q   <= k;
      cnt_q   <= cnt;
      found_q <= hit;
      nf1_q   <= nf0_q | ~hit;
      ph1_q   <= ph0_q;
      tl1_q   <= tl0_q;
    end
  end

  assign bus.m_vld            = v1_q;
  assign bus.x0               = x0_q;
  assign bus.y_sub_y0         = y0_q;
  assign bus.y_sub_y1         = y1_q;
  assign bus.idx_o            = idx_q;
  assign bus.cnt_o            = cnt_q;
  assign bus.found_o          = found_q;
  assign bus.not_found_o      = nf1_q;
  assign bus.abs_phase1_pos_o = ph1_q;
  assign bus.tlast_o          = tl1_q;

endmodule

// File: tb/tb_zero_cross_search.sv
// Scoreboard bench for zero_cross_search with WIN_SIZE=8: directed windows,
// a back-to-back burst under random backpressure, and a mid-flight reset.
module tb_zero_cross_search;
  import pmp_pkg::*;

  localparam int DW = 16;
  localparam int WS = 8;
  localparam int IW = zc_idx_w(WS);
  localparam int OW = 4 * DW + 2 * IW + 3;

  typedef logic [WS-1:0][DW-1:0] win_t;

  typedef struct {
    logic [DW-1:0] x0, y0, y1, ph;
    logic [IW-1:0] idx, cnt;
    logic          found, nf, tl;
    int            acc_cyc;
    bit            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zero_cross_search_if #(.DATA_WIDTH(DW), .WIN_SIZE(WS)) bus ();

  zero_cross_search #(.DATA_WIDTH(DW), .WIN_SIZE(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  logic [OW-1:0] outs;
  assign outs = {bus.x0, bus.y_sub_y0, bus.y_sub_y1, bus.idx_o, bus.cnt_o,
                 bus.found_o, bus.not_found_o, bus.abs_phase1_pos_o, bus.tlast_o};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: scan every adjacent pair using signed arithmetic.
  function automatic exp_t model(input win_t e, input win_t p, input logic [1:0] m,
                                 input logic f, input logic [DW-1:0] ph,
                                 input logic nf, input logic tl);
    exp_t r;
    int   k, n;
    bit   hit;
    k = 0; n = 0; hit = 0;
    for (int i = 0; i < WS - 1; i++) begin
      int a, b;
      bit fall, rise, mt;
      a    = int'($signed(e[i]));
      b    = int'($signed(e[i+1]));
      fall = (a >= 0) && (b < 0);
      rise = (a < 0) && (b >= 0);
      mt   = (m == 2'b01) ? rise : (m == 2'b10) ? (fall || rise) : fall;
      if (mt) begin
        n++;
        if (!f || !hit) k = i;
        hit = 1;
      end
    end
    r.x0 = p[k]; r.y0 = e[k]; r.y1 = e[k+1];
    r.idx = IW'(k); r.cnt = IW'(n);
    r.found = hit; r.nf = nf | !hit; r.ph = ph; r.tl = tl;
    r.acc_cyc = 0; r.lat = 0;
    return r;
  endfunction

  function automatic win_t pack8(input int a[8]);
    win_t r;
    for (int i = 0; i < WS; i++) r[i] = DW'(a[i]);
    return r;
  endfunction

  function automatic win_t mkpos(input int base);
    win_t r;
    for (int i = 0; i < WS; i++) r[i] = DW'(base + 3 * i);
    return r;
  endfunction

  task automatic send(input win_t e, input win_t p, input logic [1:0] m, input logic f,
                      input logic [DW-1:0] ph, input logic nf, input logic tl,
                      input bit lat, input bit rnd);
    exp_t x;
    bit   ok;
    bus.s_vld = 1'b1; bus.error_i = e; bus.pos_i = p; bus.mode_i = m;
    bus.first_i = f; bus.abs_phase1_pos_i = ph; bus.not_found_i = nf; bus.tlast_i = tl;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.s_rdy) begin
        ok = 1;
        x = model(e, p, m, f, ph, nf, tl);
        x.lat = lat;
        x.acc_cyc = cyc;
        sbq.push_back(x);
      end
      @(posedge clk);
      #1;
      if (rnd) bus.m_rdy = 1'($urandom_range(0, 1));
    end
    if (!ok) chk("accept_timeout", 0, 1);
    bus.s_vld = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
    chk("drain_empty", 128'(sbq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  exp_t          mx;
  bit            stalled = 0;
  logic [OW-1:0] snap;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) chk("stall_hold", 128'(outs), 128'(snap));
      stalled = bus.m_vld && !bus.m_rdy;
      snap = outs;
      if (bus.m_vld && bus.m_rdy) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mx = sbq.pop_front();
          chk("x0", bus.x0, mx.x0);
          chk("y_sub_y0", bus.y_sub_y0, mx.y0);
          chk("y_sub_y1", bus.y_sub_y1, mx.y1);
          chk("idx", bus.idx_o, mx.idx);
          chk("cnt", bus.cnt_o, mx.cnt);
          chk("found", bus.found_o, mx.found);
          chk("not_found", bus.not_found_o, mx.nf);
          chk("phase1_pos", bus.abs_phase1_pos_o, mx.ph);
          chk("tlast", bus.tlast_o, mx.tl);
          if (mx.lat) chk("latency", 128'(cyc - mx.acc_cyc), 2);
        end
      end
    end
  end

  int   arr[8];
  win_t ea, eb;

  initial begin
    bus.s_vld = 1'b0; bus.m_rdy = 1'b1; bus.error_i = '0; bus.pos_i = '0;
    bus.mode_i = 2'b00; bus.first_i = 1'b0; bus.abs_phase1_pos_i = '0;
    bus.not_found_i = 1'b0; bus.tlast_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_rdy", bus.s_rdy, 1);
    chk("rst_m_vld", bus.m_vld, 0);
    chk("rst_outs", 128'(outs), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_rdy", bus.s_rdy, 1);
    @(posedge clk);
    #1;

    arr = '{5, 3, 1, -2, -4, -6, -8, -9};
    ea = pack8(arr);
    send(ea, mkpos(100), 2'b00, 1'b1, 16'h0011, 1'b0, 1'b0, 1, 0);
    drain();

    arr = '{2, -1, 3, -1, 0, -5, 4, 4};
    eb = pack8(arr);
    send(eb, mkpos(200), 2'b00, 1'b0, 16'h0022, 1'b0, 1'b0, 1, 0);
    drain();
    send(eb, mkpos(300), 2'b00, 1'b1, 16'h0033, 1'b0, 1'b0, 1, 0);
    drain();
    send(eb, mkpos(400), 2'b10, 1'b0, 16'h0044, 1'b0, 1'b0, 1, 0);
    drain();
    send(eb, mkpos(500), 2'b11, 1'b0, 16'h0055, 1'b0, 1'b0, 1, 0);
    drain();
    send(eb, mkpos(600), 2'b01, 1'b1, 16'h0066, 1'b1, 1'b0, 1, 0);
    drain();

    arr = '{1, 2, 3, 4, 5, 6, 7, 8};
    send(pack8(arr), mkpos(700), 2'b10, 1'b1, 16'h0077, 1'b0, 1'b0, 1, 0);
    drain();

    arr = '{0, -1, -1, -1, -1, -1, -1, -1};
    send(pack8(arr), mkpos(800), 2'b00, 1'b1, 16'h0088, 1'b0, 1'b0, 1, 0);
    send(pack8(arr), mkpos(810), 2'b01, 1'b1, 16'h0089, 1'b0, 1'b0, 0, 0);
    drain();
    arr = '{-1, 0, 0, 0, 0, 0, 0, 0};
    send(pack8(arr), mkpos(900), 2'b01, 1'b0, 16'h0099, 1'b0, 1'b0, 1, 0);
    send(pack8(arr), mkpos(910), 2'b00, 1'b0, 16'h009a, 1'b0, 1'b0, 0, 0);
    drain();

    for (int n = 0; n < 20; n++) begin
      win_t er;
      for (int i = 0; i < WS; i++) er[i] = DW'(int'($urandom_range(0, 20)) - 10);
      send(er, mkpos(n * 100 - 50), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           DW'(1000 + n), 1'($urandom_range(0, 1)), 1'(n == 19), 0, 1);
    end
    bus.m_rdy = 1'b1;
    drain();

    bus.m_rdy = 1'b0;
    send(ea, mkpos(40), 2'b00, 1'b1, 16'h0aaa, 1'b0, 1'b0, 0, 0);
    send(eb, mkpos(60), 2'b10, 1'b0, 16'h0bbb, 1'b0, 1'b1, 0, 0);
    chk("full_s_rdy", bus.s_rdy, 0);
    chk("full_m_vld", bus.m_vld, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_vld", bus.m_vld, 0);
    chk("mid_rst_outs", 128'(outs), 0);
    chk("mid_rst_s_rdy", bus.s_rdy, 1);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rel_s_rdy", bus.s_rdy, 1);
    bus.m_rdy = 1'b1;
    send(eb, mkpos(80), 2'b00, 1'b0, 16'h0ccc, 1'b0, 1'b1, 1, 0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
